// File: rtl/riscv_pkg.sv
// Shared RISC-V encodings, stage-3 FSM states and the stage-3 input register payload.
package riscv_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned OPC_W    = 7;
    localparam int unsigned F3_W     = 3;
    localparam int unsigned REG_AW   = 5;
    localparam int unsigned CSR_AW   = 12;
    localparam int unsigned STRB_W   = XLEN / 8;

    localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
    localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
    localparam logic [OPC_W-1:0] OPC_OP     = 7'b0110011;
    localparam logic [OPC_W-1:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
    localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;
    localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;
    localparam logic [OPC_W-1:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [F3_W-1:0] F3_B  = 3'b000;
    localparam logic [F3_W-1:0] F3_H  = 3'b001;
    localparam logic [F3_W-1:0] F3_W_ = 3'b010;
    localparam logic [F3_W-1:0] F3_BU = 3'b100;
    localparam logic [F3_W-1:0] F3_HU = 3'b101;

    localparam logic [F3_W-1:0] F3_CSRRW  = 3'b001;
    localparam logic [F3_W-1:0] F3_CSRRWI = 3'b101;

    localparam logic [XLEN-1:0]   NOP_INST   = 32'h0000_0013;
    localparam logic [CSR_AW-1:0] CSR_TOHOST = 12'h51E;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } stage3_state_e;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] inst;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] alu;
        logic [XLEN-1:0] rs2;
    } stage3_reg_t;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store strobes/replicated data and load extraction with extension.
module lsu_align
    import riscv_pkg::*;
(
    input  logic [F3_W-1:0]   funct3,
    input  logic [1:0]        offset,
    input  logic [XLEN-1:0]   rs2,
    input  logic [XLEN-1:0]   resp_data,
    output logic [STRB_W-1:0] wstrb,
    output logic [XLEN-1:0]   wdata,
    output logic [XLEN-1:0]   load_data
);

    logic [XLEN-1:0] shifted;

    always_comb begin
        wstrb     = '0;
        wdata     = rs2;
        load_data = '0;
        shifted   = resp_data >> {offset, 3'b000};

        case (funct3)
            F3_B: begin
                wstrb = STRB_W'(4'b0001 << offset);
                wdata = {4{rs2[7:0]}};
            end
            F3_H: begin
                wstrb = STRB_W'(4'b0011 << {offset[1], 1'b0});
                wdata = {2{rs2[15:0]}};
            end
            F3_W_: begin
                wstrb = 4'hF;
                wdata = rs2;
            end
            default: ;
        endcase

        case (funct3)
            F3_B:    load_data = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    load_data = {{16{shifted[15]}}, shifted[15:0]};
            F3_W_:   load_data = shifted;
            F3_BU:   load_data = {24'h0, shifted[7:0]};
            F3_HU:   load_data = {16'h0, shifted[15:0]};
            default: load_data = '0;
        endcase
    end

endmodule

// File: rtl/stage3_mem_wb.sv
// Memory/writeback stage: input register, dmem load/store handshake FSM, RF writeback.
// Optional tohost CSR (12'h51E) enabled by defining STAGE3_CSR_EN.
module stage3_mem_wb
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stage2_valid,
    input  logic [XLEN-1:0]     stage2_inst_in,
    input  logic [XLEN-1:0]     stage2_pc_in,
    input  logic [XLEN-1:0]     stage2_alu_in,
    input  logic [XLEN-1:0]     stage2_rs2_data_in,
    output logic                dmem_req_valid,
    input  logic                dmem_req_ready,
    output logic                dmem_req_we,
    output logic [XLEN-1:0]     dmem_addr,
    output logic [XLEN-1:0]     dmem_wdata,
    output logic [STRB_W-1:0]   dmem_wstrb,
    input  logic                dmem_resp_valid,
    input  logic [XLEN-1:0]     dmem_resp_data,
    output logic [XLEN-1:0]     stage3_inst,
    output logic [XLEN-1:0]     wb_data,
    output logic                rf_we,
    output logic [REG_AW-1:0]   rf_wa,
    output logic                stall
`ifdef STAGE3_CSR_EN
    ,
    output logic [XLEN-1:0]     csr_tohost
`endif
);

    stage3_reg_t      held_q;
    stage3_reg_t      held_d;
    stage3_state_e    state_q;
    stage3_state_e    state_d;

    logic [OPC_W-1:0]  opcode;
    logic [F3_W-1:0]   funct3;
    logic              is_load;
    logic              is_store;
    logic              cap_mem;
    logic              wb_op;
    logic [STRB_W-1:0] align_wstrb;
    logic [XLEN-1:0]   align_wdata;
    logic [XLEN-1:0]   load_data;
    logic              csr_hit;

    assign opcode   = held_q.inst[6:0];
    assign funct3   = held_q.inst[14:12];
    assign is_load  = (opcode == OPC_LOAD);
    assign is_store = (opcode == OPC_STORE);
    assign cap_mem  = stage2_valid &&
                      ((stage2_inst_in[6:0] == OPC_LOAD) || (stage2_inst_in[6:0] == OPC_STORE));
    assign stall    = (state_q == ST_REQ) || ((state_q == ST_RESP) && !dmem_resp_valid);

`ifdef STAGE3_CSR_EN
    assign csr_hit = (opcode == OPC_SYSTEM) &&
                     ((funct3 == F3_CSRRW) || (funct3 == F3_CSRRWI)) &&
                     (held_q.inst[31:20] == CSR_TOHOST);
`else
    assign csr_hit = 1'b0;
`endif

    // Flushed captures carry a NOP so forwarding never matches a dead instruction.
    always_comb begin
        held_d.valid = stage2_valid;
        held_d.inst  = stage2_valid ? stage2_inst_in : NOP_INST;
        held_d.pc    = stage2_pc_in;
        held_d.alu   = stage2_alu_in;
        held_d.rs2   = stage2_rs2_data_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            held_q.valid <= 1'b0;
            held_q.inst  <= NOP_INST;
            held_q.pc    <= RESET_PC;
            held_q.alu   <= '0;
            held_q.rs2   <= '0;
            state_q      <= ST_IDLE;
        end else begin
            if (!stall) begin
                held_q <= held_d;
            end
            state_q <= state_d;
        end
    end

`ifdef STAGE3_CSR_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            csr_tohost <= '0;
        end else if (!stall && held_q.valid && csr_hit) begin
            csr_tohost <= held_q.alu;
        end
    end
`endif

    lsu_align u_lsu_align (
        .funct3    (funct3),
        .offset    (held_q.alu[1:0]),
        .rs2       (held_q.rs2),
        .resp_data (dmem_resp_data),
        .wstrb     (align_wstrb),
        .wdata     (align_wdata),
        .load_data (load_data)
    );

    // Next state follows the capture whenever the input register advances.
    always_comb begin
        state_d        = state_q;
        dmem_req_valid = 1'b0;
        dmem_req_we    = 1'b0;
        dmem_wstrb     = '0;
        dmem_addr      = {held_q.alu[31:2], 2'b00};
        dmem_wdata     = align_wdata;
        wb_data        = held_q.alu;
        wb_op          = 1'b0;

        if (!stall) begin
            state_d = cap_mem ? ST_REQ : ST_IDLE;
        end else if ((state_q == ST_REQ) && dmem_req_ready) begin
            state_d = is_load ? ST_RESP : ST_IDLE;
        end

        if (state_q == ST_REQ) begin
            dmem_req_valid = 1'b1;
            dmem_req_we    = is_store;
            dmem_wstrb     = is_store ? align_wstrb : '0;
        end

        case (opcode)
            OPC_LOAD:             wb_data = load_data;
            OPC_JAL, OPC_JALR:    wb_data = held_q.pc + 32'd4;
`ifdef STAGE3_CSR_EN
            OPC_SYSTEM:           wb_data = csr_hit ? csr_tohost : held_q.alu;
`endif
            default:              wb_data = held_q.alu;
        endcase

        case (opcode)
            OPC_LOAD, OPC_OP, OPC_OP_IMM, OPC_LUI,
            OPC_AUIPC, OPC_JAL, OPC_JALR: wb_op = 1'b1;
            OPC_SYSTEM:                   wb_op = csr_hit;
            default:                      wb_op = 1'b0;
        endcase
    end

    assign stage3_inst = held_q.inst;
    assign rf_wa       = held_q.inst[11:7];
    assign rf_we       = held_q.valid && !stall && (rf_wa != 5'd0) && wb_op;

endmodule

// File: tb/tb_stage3_mem_wb.sv
// Directed bench for stage3_mem_wb: ALU writeback, store/load handshakes, flush and reset.
`timescale 1ns/1ps
module tb_stage3_mem_wb;

    logic        clk = 1'b0;
    logic        rst;
    logic        stage2_valid;
    logic [31:0] stage2_inst_in;
    logic [31:0] stage2_pc_in;
    logic [31:0] stage2_alu_in;
    logic [31:0] stage2_rs2_data_in;
    logic        dmem_req_valid;
    logic        dmem_req_ready;
    logic        dmem_req_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic        dmem_resp_valid;
    logic [31:0] dmem_resp_data;
    logic [31:0] stage3_inst;
    logic [31:0] wb_data;
    logic        rf_we;
    logic [4:0]  rf_wa;
    logic        stall;
`ifdef STAGE3_CSR_EN
    logic [31:0] csr_tohost;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [31:0] NOP = 32'h0000_0013;

    always #5 clk = ~clk;

    stage3_mem_wb #(.RESET_PC(32'h0000_0000)) dut (
        .clk                (clk),
        .rst                (rst),
        .stage2_valid       (stage2_valid),
        .stage2_inst_in     (stage2_inst_in),
        .stage2_pc_in       (stage2_pc_in),
        .stage2_alu_in      (stage2_alu_in),
        .stage2_rs2_data_in (stage2_rs2_data_in),
        .dmem_req_valid     (dmem_req_valid),
        .dmem_req_ready     (dmem_req_ready),
        .dmem_req_we        (dmem_req_we),
        .dmem_addr          (dmem_addr),
        .dmem_wdata         (dmem_wdata),
        .dmem_wstrb         (dmem_wstrb),
        .dmem_resp_valid    (dmem_resp_valid),
        .dmem_resp_data     (dmem_resp_data),
        .stage3_inst        (stage3_inst),
        .wb_data            (wb_data),
        .rf_we              (rf_we),
        .rf_wa              (rf_wa),
        .stall              (stall)
`ifdef STAGE3_CSR_EN
        ,
        .csr_tohost         (csr_tohost)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                         input logic [31:0] alu, input logic [31:0] rs2);
        stage2_valid       = v;
        stage2_inst_in     = inst;
        stage2_pc_in       = pc;
        stage2_alu_in      = alu;
        stage2_rs2_data_in = rs2;
    endtask

    task automatic bubble();
        drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bubble();
        dmem_req_ready  = 1'b0;
        dmem_resp_valid = 1'b0;
        dmem_resp_data  = 32'h0;
        tick();
        tick();
        n_checks++;
        if (dmem_req_valid !== 1'b0 || rf_we !== 1'b0 || stall !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: req_valid=%b rf_we=%b stall=%b, want 0 0 0",
                     dmem_req_valid, rf_we, stall);
        end
        n_checks++;
        if (stage3_inst !== NOP || wb_data !== 32'h0 || dmem_wstrb !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_data: inst=%h wb=%h wstrb=%h, want %h 0 0",
                     stage3_inst, wb_data, dmem_wstrb, NOP);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_alu();
        drive(1'b1, 32'h02A0_0293, 32'h0000_0100, 32'h0000_002A, 32'h0);
        tick();
        drive(1'b1, 32'h0070_0313, 32'h0000_0104, 32'h0000_0007, 32'h0);
        n_checks++;
        if (rf_we !== 1'b1 || rf_wa !== 5'd5 || wb_data !== 32'h2A || stall !== 1'b0) begin
            n_fail++;
            $display("FAIL addi_wb: we=%b wa=%0d wb=%h stall=%b, want 1 5 0000002a 0",
                     rf_we, rf_wa, wb_data, stall);
        end
        tick();
        bubble();
        n_checks++;
        if (rf_we !== 1'b1 || rf_wa !== 5'd6 || wb_data !== 32'h7) begin
            n_fail++;
            $display("FAIL b2b_addi_wb: we=%b wa=%0d wb=%h, want 1 6 00000007",
                     rf_we, rf_wa, wb_data);
        end
        tick();
    endtask

    task automatic test_store();
        dmem_req_ready = 1'b1;
        drive(1'b1, 32'h0020_8023, 32'h0000_0200, 32'h0000_1003, 32'h1234_5678);
        tick();
        bubble();
        n_checks++;
        if (dmem_req_valid !== 1'b1 || dmem_req_we !== 1'b1 || stall !== 1'b1 || rf_we !== 1'b0) begin
            n_fail++;
            $display("FAIL sb_req: req=%b we=%b stall=%b rf_we=%b, want 1 1 1 0",
                     dmem_req_valid, dmem_req_we, stall, rf_we);
        end
        n_checks++;
        if (dmem_wstrb !== 4'b1000 || dmem_wdata !== 32'h7878_7878 || dmem_addr !== 32'h0000_1000) begin
            n_fail++;
            $display("FAIL sb_lanes: wstrb=%b wdata=%h addr=%h, want 1000 78787878 00001000",
                     dmem_wstrb, dmem_wdata, dmem_addr);
        end
        tick();
        n_checks++;
        if (stall !== 1'b0 || dmem_req_valid !== 1'b0 || dmem_wstrb !== 4'h0 || rf_we !== 1'b0) begin
            n_fail++;
            $display("FAIL sb_done: stall=%b req=%b wstrb=%b rf_we=%b, want 0 0 0000 0",
                     stall, dmem_req_valid, dmem_wstrb, rf_we);
        end
        tick();
    endtask

    task automatic test_load_lh();
        dmem_req_ready = 1'b1;
        drive(1'b1, 32'h0000_9303, 32'h0000_0300, 32'h0000_2002, 32'h0);
        tick();
        bubble();
        n_checks++;
        if (stall !== 1'b1 || dmem_req_valid !== 1'b1 || dmem_req_we !== 1'b0 || dmem_addr !== 32'h2000) begin
            n_fail++;
            $display("FAIL lh_req: stall=%b req=%b we=%b addr=%h, want 1 1 0 00002000",
                     stall, dmem_req_valid, dmem_req_we, dmem_addr);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            n_checks++;
            if (stall !== 1'b1 || dmem_req_valid !== 1'b0 || rf_we !== 1'b0) begin
                n_fail++;
                $display("FAIL lh_resp_wait%0d: stall=%b req=%b rf_we=%b, want 1 0 0",
                         i, stall, dmem_req_valid, rf_we);
            end
        end
        dmem_resp_valid = 1'b1;
        dmem_resp_data  = 32'h8001_0000;
        #1;
        n_checks++;
        if (stall !== 1'b0 || rf_we !== 1'b1 || rf_wa !== 5'd6 || wb_data !== 32'hFFFF_8001) begin
            n_fail++;
            $display("FAIL lh_wb: stall=%b we=%b wa=%0d wb=%h, want 0 1 6 ffff8001",
                     stall, rf_we, rf_wa, wb_data);
        end
        tick();
        dmem_resp_valid = 1'b0;
        #1;
        n_checks++;
        if (stall !== 1'b0 || rf_we !== 1'b0) begin
            n_fail++;
            $display("FAIL lh_after: stall=%b rf_we=%b, want 0 0", stall, rf_we);
        end
        tick();
    endtask

    task automatic test_lbu_ready_low();
        dmem_req_ready = 1'b0;
        drive(1'b1, 32'h0000_C383, 32'h0000_0400, 32'h0000_3001, 32'h0);
        tick();
        bubble();
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (stall !== 1'b1 || dmem_req_valid !== 1'b1 || dmem_addr !== 32'h3000 ||
                dmem_req_we !== 1'b0 || dmem_wstrb !== 4'h0) begin
                n_fail++;
                $display("FAIL lbu_hold%0d: stall=%b req=%b addr=%h we=%b wstrb=%b, want 1 1 00003000 0 0000",
                         i, stall, dmem_req_valid, dmem_addr, dmem_req_we, dmem_wstrb);
            end
            tick();
        end
        dmem_req_ready = 1'b1;
        tick();
        dmem_resp_valid = 1'b1;
        dmem_resp_data  = 32'h0000_AB00;
        #1;
        n_checks++;
        if (rf_we !== 1'b1 || rf_wa !== 5'd7 || wb_data !== 32'h0000_00AB || stall !== 1'b0) begin
            n_fail++;
            $display("FAIL lbu_wb: we=%b wa=%0d wb=%h stall=%b, want 1 7 000000ab 0",
                     rf_we, rf_wa, wb_data, stall);
        end
        tick();
        dmem_resp_valid = 1'b0;
        tick();
    endtask

    task automatic test_jal_flush();
        drive(1'b1, 32'h0000_00EF, 32'hFFFF_FFFC, 32'h0000_1234, 32'h0);
        tick();
        drive(1'b0, 32'h02A0_0293, 32'h0000_0000, 32'h0000_0055, 32'h0);
        n_checks++;
        if (rf_we !== 1'b1 || rf_wa !== 5'd1 || wb_data !== 32'h0000_0000) begin
            n_fail++;
            $display("FAIL jal_wrap: we=%b wa=%0d wb=%h, want 1 1 00000000", rf_we, rf_wa, wb_data);
        end
        tick();
        bubble();
        n_checks++;
        if (stage3_inst !== NOP || rf_we !== 1'b0 || stall !== 1'b0) begin
            n_fail++;
            $display("FAIL flush: inst=%h rf_we=%b stall=%b, want %h 0 0", stage3_inst, rf_we, stall, NOP);
        end
        tick();
    endtask

    task automatic test_reset_in_resp();
        dmem_req_ready = 1'b1;
        drive(1'b1, 32'h0000_A403, 32'h0000_0500, 32'h0000_4000, 32'h0);
        tick();
        bubble();
        tick();
        n_checks++;
        if (stall !== 1'b1 || dmem_req_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rr_in_resp: stall=%b req=%b, want 1 0", stall, dmem_req_valid);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if (stall !== 1'b0 || dmem_req_valid !== 1'b0 || stage3_inst !== NOP) begin
            n_fail++;
            $display("FAIL rr_idle: stall=%b req=%b inst=%h, want 0 0 %h", stall, dmem_req_valid, stage3_inst, NOP);
        end
        dmem_resp_valid = 1'b1;
        dmem_resp_data  = 32'hDEAD_BEEF;
        #1;
        n_checks++;
        if (rf_we !== 1'b0 || stall !== 1'b0) begin
            n_fail++;
            $display("FAIL rr_late_resp: rf_we=%b stall=%b, want 0 0", rf_we, stall);
        end
        tick();
        dmem_resp_valid = 1'b0;
        #1;
        n_checks++;
        if (rf_we !== 1'b0 || stall !== 1'b0 || dmem_req_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rr_after: rf_we=%b stall=%b req=%b, want 0 0 0", rf_we, stall, dmem_req_valid);
        end
        tick();
    endtask

`ifdef STAGE3_CSR_EN
    task automatic test_csr();
        drive(1'b1, 32'h51E0_94F3, 32'h0000_0600, 32'h0000_0001, 32'h0);
        tick();
        bubble();
        n_checks++;
        if (rf_we !== 1'b1 || rf_wa !== 5'd9 || wb_data !== 32'h0 || csr_tohost !== 32'h0) begin
            n_fail++;
            $display("FAIL csr_old: we=%b wa=%0d wb=%h tohost=%h, want 1 9 0 0",
                     rf_we, rf_wa, wb_data, csr_tohost);
        end
        tick();
        n_checks++;
        if (csr_tohost !== 32'h1) begin
            n_fail++;
            $display("FAIL csr_tohost: got %h, want 00000001", csr_tohost);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_alu();
        test_store();
        test_load_lh();
        test_lbu_ready_low();
        test_jal_flush();
        test_reset_in_resp();
`ifdef STAGE3_CSR_EN
        test_csr();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
